// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter register and next-PC sequencing FSM
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        is_ebreak,
  input  logic        resume,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        mrs1andpc_ctr2,
  output logic        instr_valid,
  output logic        trap,
  output logic [31:0] bad_pc,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10,
    TRAP = 2'b11
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] bad_pc_q;
  logic [31:0] base;
  logic [31:0] sum;
  logic [31:0] target;
  logic        redirect;

  assign state          = state_q;
  assign pc             = pc_q;
  assign bad_pc         = bad_pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign mrs1andpc_ctr2 = (state_q == RUN) && is_jalr;
  assign instr_valid    = (state_q == RUN) && !stall;
  assign trap           = (state_q == TRAP);

  // JALR already selects rs1 as the base, so it wins over JAL without a separate path.
  always_comb begin
    base     = mrs1andpc_ctr2 ? rs1 : pc_q;
    sum      = base + imm;
    target   = {sum[31:1], sum[0] & ~is_jalr};
    redirect = is_jalr || is_jal || (is_branch && branch_taken);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VECTOR;
      bad_pc_q <= 32'h0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (!stall) begin
            if (is_ebreak) begin
              state_q <= HALT;
            end else if (redirect) begin
              if (target[1]) begin
                pc_q     <= TRAP_VECTOR;
                bad_pc_q <= pc_q;
                state_q  <= TRAP;
              end else begin
                pc_q <= target;
              end
            end else begin
              pc_q <= pc_plus4;
            end
          end
        end
        HALT: begin
          if (resume && !stall) begin
            pc_q    <= pc_plus4;
            state_q <= RUN;
          end
        end
        TRAP: state_q <= RUN;
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  localparam logic [1:0] S_BOOT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;
  localparam logic [1:0] S_TRAP = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        is_branch;
  logic        branch_taken;
  logic        is_jal;
  logic        is_jalr;
  logic        is_ebreak;
  logic        resume;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        mrs1andpc_ctr2;
  logic        instr_valid;
  logic        trap;
  logic [31:0] bad_pc;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  st;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .is_branch      (is_branch),
    .branch_taken   (branch_taken),
    .is_jal         (is_jal),
    .is_jalr        (is_jalr),
    .is_ebreak      (is_ebreak),
    .resume         (resume),
    .imm            (imm),
    .rs1            (rs1),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .mrs1andpc_ctr2 (mrs1andpc_ctr2),
    .instr_valid    (instr_valid),
    .trap           (trap),
    .bad_pc         (bad_pc),
    .state          (state)
  );

  task automatic set_in(input logic br, input logic tk, input logic jal, input logic jalr,
                        input logic eb, input logic res, input logic stl,
                        input logic [31:0] im, input logic [31:0] r1);
    is_branch = br; branch_taken = tk; is_jal = jal; is_jalr = jalr;
    is_ebreak = eb; resume = res; stall = stl; imm = im; rs1 = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [1:0] s, input string t);
    exp_t x;
    x.pc = p; x.st = s; x.tag = t;
    sbq.push_back(x);
  endtask

  task automatic goto_pc(input logic [31:0] t);
    set_in(0, 0, 0, 1, 0, 0, 0, 32'h0, t);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    tick();
    checks++;
    if (pc !== 32'h0 || state !== S_BOOT || instr_valid !== 1'b0 || trap !== 1'b0 || bad_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset: pc=%h state=%0d iv=%b trap=%b bad_pc=%h, expected pc=0 state=0 iv=0 trap=0 bad_pc=0",
               pc, state, instr_valid, trap, bad_pc);
    end
    rst = 1'b0;
    push(32'h0, S_RUN, "boot_to_run");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
    end
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_iv: instr_valid=%b at pc=%h, expected 1", instr_valid, pc);
      end
      push(32'(i * 4), S_RUN, "seq");
      tick();
      e = sbq.pop_front(); checks++;
      if (pc !== e.pc || state !== e.st) begin
        errors++;
        $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
      end
    end
  endtask

  task automatic test_jalr();
    goto_pc(32'h8);
    set_in(0, 0, 0, 1, 0, 0, 0, 32'h0000_000F, 32'h0000_0101);
    #1;
    checks++;
    if (mrs1andpc_ctr2 !== 1'b1 || pc_plus4 !== 32'hC) begin
      errors++;
      $display("FAIL jalr_sel: ctr2=%b pc_plus4=%h, expected ctr2=1 pc_plus4=0000000c", mrs1andpc_ctr2, pc_plus4);
    end
    push(32'h110, S_RUN, "jalr_target");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
    end
  endtask

  task automatic test_branch_jal();
    goto_pc(32'h20);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin set_in(1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0); push(32'h24, S_RUN, "branch_not_taken"); end
        1: begin set_in(1, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0); push(32'h1C, S_RUN, "branch_taken"); end
        default: begin set_in(0, 0, 1, 0, 0, 0, 0, 32'h40, 32'hDEAD_0000); push(32'h5C, S_RUN, "jal"); end
      endcase
      #1;
      checks++;
      if (mrs1andpc_ctr2 !== 1'b0) begin
        errors++;
        $display("FAIL branch_sel: ctr2=%b, expected 0", mrs1andpc_ctr2);
      end
      tick();
      e = sbq.pop_front(); checks++;
      if (pc !== e.pc || state !== e.st) begin
        errors++;
        $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
      end
    end
    set_in(0, 0, 1, 0, 0, 0, 1, 32'h40, 32'h0);
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_iv: instr_valid=%b, expected 0", instr_valid);
    end
    push(32'h5C, S_RUN, "stall_hold");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_trap();
    goto_pc(32'h8);
    set_in(1, 1, 0, 0, 0, 0, 0, 32'h6, 32'h0);
    push(32'h100, S_TRAP, "trap_entry");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    #1;
    checks++;
    if (trap !== 1'b1 || bad_pc !== 32'h8 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL trap_flags: trap=%b bad_pc=%h iv=%b, expected trap=1 bad_pc=00000008 iv=0", trap, bad_pc, instr_valid);
    end
    stall = 1'b1;
    push(32'h100, S_RUN, "trap_exit");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
    end
    stall = 1'b0;
    #1;
    checks++;
    if (trap !== 1'b0) begin
      errors++;
      $display("FAIL trap_clear: trap=%b, expected 0", trap);
    end
    set_in(0, 0, 0, 1, 0, 0, 0, 32'h1, 32'h0000_0201);
    push(32'h100, S_TRAP, "jalr_misaligned");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st || bad_pc !== 32'h100) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d bad_pc=%h, expected pc=%h state=%0d bad_pc=00000100",
               e.tag, pc, state, bad_pc, e.pc, e.st);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_halt();
    goto_pc(32'h30);
    set_in(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    push(32'h30, S_HALT, "ebreak");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
    end
    set_in(0, 0, 1, 0, 0, 0, 0, 32'h40, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_iv: instr_valid=%b cycle %0d, expected 0", instr_valid, i);
      end
      push(32'h30, S_HALT, "halt_hold");
      tick();
      e = sbq.pop_front(); checks++;
      if (pc !== e.pc || state !== e.st) begin
        errors++;
        $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
      end
    end
    set_in(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0);
    push(32'h30, S_HALT, "resume_stalled");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
    end
    stall = 1'b0;
    push(32'h34, S_RUN, "resume");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_wrap_priority();
    goto_pc(32'hFFFF_FFFC);
    push(32'h0, S_RUN, "wrap");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
    end
    set_in(1, 1, 1, 1, 0, 0, 0, 32'h4, 32'h200);
    push(32'h204, S_RUN, "jal_jalr_prio");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
    end
    set_in(0, 0, 0, 1, 1, 0, 0, 32'h2, 32'h0);
    push(32'h204, S_HALT, "ebreak_prio");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
    end
    set_in(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    rst = 1'b1;
    push(32'h0, S_BOOT, "halt_reset");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d iv=%b, expected pc=%h state=%0d iv=0", e.tag, pc, state, instr_valid, e.pc, e.st);
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    push(32'h0, S_RUN, "post_reset_run");
    tick();
    e = sbq.pop_front(); checks++;
    if (pc !== e.pc || state !== e.st) begin
      errors++;
      $display("FAIL %s: pc=%h state=%0d, expected pc=%h state=%0d", e.tag, pc, state, e.pc, e.st);
    end
  endtask

  initial begin
    test_reset();
    test_jalr();
    test_branch_jal();
    test_trap();
    test_halt();
    test_wrap_priority();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
